// File: rtl/iob_eth_mdio_master.sv
// iob_eth_mdio_master: MII management (MDC/MDIO) master.
// Accepts a Clause 22 (or optionally Clause 45) request on a valid/ready port,
// serialises the frame MSB first with one bit per MDC period, and reports read
// data and status on a single-cycle response strobe.
module iob_eth_mdio_master #(
    parameter int MDC_HALF_DIV = 5,
    parameter int PREAMBLE_LEN = 32,
    parameter int CLAUSE45_EN  = 0
) (
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_st_i,
    input  logic [1:0]  req_op_i,
    input  logic [4:0]  req_phyad_i,
    input  logic [4:0]  req_regad_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        mii_mdc_o,
    output logic        mii_mdio_o,
    output logic        mii_mdio_oe_o,
    input  logic        mii_mdio_i
);

    localparam logic [7:0] DIV_LAST = 8'(MDC_HALF_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_END,
        S_RSP
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  nxt_cnt;
    logic [31:0] tx_sr;
    logic [15:0] rx_sr;
    logic        is_read;
    logic        ta_err;
    logic        div_wrap;
    logic        nxt_bit;
    logic        nxt_drive;
    logic        nxt_mdio;
    logic        req_illegal;
    logic        req_is_read;
    logic [31:0] req_frame;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Decode the incoming request: legality, read/write direction and the
    // 32-bit ST/OP/PHYAD/REGAD/TA/DATA word shifted out after the preamble.
    always_comb begin
        req_illegal = (CLAUSE45_EN == 0) &&
                      (!req_st_i || (req_op_i == 2'b00) || (req_op_i == 2'b11));
        req_is_read = req_st_i ? (req_op_i == 2'b10) : req_op_i[1];
        req_frame   = {1'b0, req_st_i, req_op_i, req_phyad_i, req_regad_i,
                       2'b10, req_wdata_i};
    end

    // Work out what the next bit slot looks like, applied on the MDC falling edge.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt + 6'd1;
        case (state)
            S_PRE: begin
                if (bit_cnt == PRE_LAST) begin
                    nxt_state = S_HDR;
                    nxt_cnt   = '0;
                end
            end
            S_HDR: begin
                if (bit_cnt == 6'd13) begin
                    nxt_state = S_TA;
                    nxt_cnt   = '0;
                end
            end
            S_TA: begin
                if (bit_cnt == 6'd1) begin
                    nxt_state = S_DATA;
                    nxt_cnt   = '0;
                end
            end
            S_DATA: begin
                if (bit_cnt == 6'd15) begin
                    nxt_state = S_END;
                    nxt_cnt   = '0;
                end
            end
            S_END: begin
                nxt_state = S_RSP;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = state;
            end
        endcase
        if (state == S_PRE) begin
            nxt_bit = (nxt_state == S_PRE) ? 1'b1 : tx_sr[31];
        end else begin
            nxt_bit = tx_sr[30];
        end
        nxt_drive = (nxt_state == S_PRE) || (nxt_state == S_HDR) ||
                    (!is_read && ((nxt_state == S_TA) || (nxt_state == S_DATA)));
        nxt_mdio  = nxt_drive ? nxt_bit : 1'b1;
    end

    // Frame sequencer: MDC divider, bit shifting, read sampling and response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            is_read       <= 1'b0;
            ta_err        <= 1'b0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            busy_o        <= 1'b0;
            mii_mdc_o     <= 1'b0;
            mii_mdio_o    <= 1'b1;
            mii_mdio_oe_o <= 1'b0;
        end else if (cke_i) begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_cnt   <= '0;
                    mii_mdc_o <= 1'b0;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        is_read     <= req_is_read;
                        tx_sr       <= req_frame;
                        rx_sr       <= '0;
                        ta_err      <= 1'b0;
                        bit_cnt     <= '0;
                        if (req_illegal) begin
                            state       <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            mii_mdio_oe_o <= 1'b1;
                            if (PREAMBLE_LEN > 0) begin
                                state      <= S_PRE;
                                mii_mdio_o <= 1'b1;
                            end else begin
                                state      <= S_HDR;
                                mii_mdio_o <= req_frame[31];
                            end
                        end
                    end
                end
                S_RSP: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: begin
                    if (div_wrap) begin
                        div_cnt   <= '0;
                        mii_mdc_o <= ~mii_mdc_o;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    if (div_wrap && !mii_mdc_o && is_read) begin
                        if ((state == S_TA) && (bit_cnt == 6'd1)) begin
                            ta_err <= mii_mdio_i;
                        end
                        if (state == S_DATA) begin
                            rx_sr <= {rx_sr[14:0], mii_mdio_i};
                        end
                    end
                    if (div_wrap && mii_mdc_o) begin
                        state         <= nxt_state;
                        bit_cnt       <= nxt_cnt;
                        mii_mdio_oe_o <= nxt_drive;
                        mii_mdio_o    <= nxt_mdio;
                        if (state != S_PRE) begin
                            tx_sr <= {tx_sr[30:0], 1'b0};
                        end
                        if (state == S_END) begin
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= is_read ? rx_sr : 16'h0000;
                            rsp_err_o   <= is_read & ta_err;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_mdio_master.sv
// tb_iob_eth_mdio_master: directed self-checking bench for the MDIO master.
// Two instances: one with the full 32-bit preamble and Clause 22 only, one
// with no preamble and Clause 45 enabled; both use a half-period of 2 cycles.
`timescale 1ns/1ps
module tb_iob_eth_mdio_master;

    localparam int D = 2;

    logic clk = 1'b0;
    logic cke;
    logic rst;
    logic mdio_in;
    logic valid_a;
    logic valid_b;
    logic req_st;
    logic [1:0]  req_op;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;

    logic ready_a, rsp_a, err_a, busy_a, mdc_a, mdio_a, oe_a;
    logic ready_b, rsp_b, err_b, busy_b, mdc_b, mdio_b, oe_b;
    logic [15:0] rdata_a, rdata_b;

    logic sel;
    logic ready_s, rsp_s, err_s, busy_s, mdc_s, mdio_s, oe_s;
    logic [15:0] rdata_s;

    int n_cmp = 0;
    int n_fail = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    iob_eth_mdio_master #(
        .MDC_HALF_DIV(D),
        .PREAMBLE_LEN(32),
        .CLAUSE45_EN (0)
    ) dut_a (
        .clk_i        (clk),
        .cke_i        (cke),
        .rst_i        (rst),
        .req_valid_i  (valid_a),
        .req_ready_o  (ready_a),
        .req_st_i     (req_st),
        .req_op_i     (req_op),
        .req_phyad_i  (req_phy),
        .req_regad_i  (req_reg),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_a),
        .rsp_rdata_o  (rdata_a),
        .rsp_err_o    (err_a),
        .busy_o       (busy_a),
        .mii_mdc_o    (mdc_a),
        .mii_mdio_o   (mdio_a),
        .mii_mdio_oe_o(oe_a),
        .mii_mdio_i   (mdio_in)
    );

    iob_eth_mdio_master #(
        .MDC_HALF_DIV(D),
        .PREAMBLE_LEN(0),
        .CLAUSE45_EN (1)
    ) dut_b (
        .clk_i        (clk),
        .cke_i        (cke),
        .rst_i        (rst),
        .req_valid_i  (valid_b),
        .req_ready_o  (ready_b),
        .req_st_i     (req_st),
        .req_op_i     (req_op),
        .req_phyad_i  (req_phy),
        .req_regad_i  (req_reg),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_b),
        .rsp_rdata_o  (rdata_b),
        .rsp_err_o    (err_b),
        .busy_o       (busy_b),
        .mii_mdc_o    (mdc_b),
        .mii_mdio_o   (mdio_b),
        .mii_mdio_oe_o(oe_b),
        .mii_mdio_i   (mdio_in)
    );

    // Route the instance under test to one set of observation signals.
    always_comb begin
        ready_s = sel ? ready_b : ready_a;
        rsp_s   = sel ? rsp_b   : rsp_a;
        err_s   = sel ? err_b   : err_a;
        busy_s  = sel ? busy_b  : busy_a;
        mdc_s   = sel ? mdc_b   : mdc_a;
        mdio_s  = sel ? mdio_b  : mdio_a;
        oe_s    = sel ? oe_b    : oe_a;
        rdata_s = sel ? rdata_b : rdata_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one frame on the selected instance, acting as the PHY, and collect
    // what appeared on the wire plus the response.
    task automatic do_frame(
        input  logic s, input logic st, input logic [1:0] op,
        input  logic [4:0] phy, input logic [4:0] regad, input logic [15:0] wd,
        input  logic phy_drive, input logic [15:0] phy_data,
        input  int pre, input int pause_at, input int junk_at,
        output int lat, output logic [63:0] bits, output logic [63:0] oes,
        output logic oe_pre_ta, output logic oe_ta, output logic frozen_ok,
        output logic busy_ok, output logic [15:0] rdata, output logic err,
        output logic ready_after);
        int c;
        int nrise;
        int idx;
        int j;
        logic prev_mdc;
        logic snap_mdc, snap_mdio, snap_oe, snap_rsp;
        sel = s; req_st = st; req_op = op; req_phy = phy; req_reg = regad;
        req_wdata = wd; mdio_in = 1'b1;
        lat = -1; bits = '0; oes = '0; oe_pre_ta = 1'bx; oe_ta = 1'bx;
        frozen_ok = 1'b1; busy_ok = 1'b1; rdata = 'x; err = 1'bx; ready_after = 1'b0;
        nrise = 0; prev_mdc = 1'b0;
        if (s) valid_b = 1'b1; else valid_a = 1'b1;
        tick();
        c = 1;
        valid_a = 1'b0; valid_b = 1'b0;
        while (c < 3000 && lat < 0) begin
            if (mdc_s && !prev_mdc) begin
                if (nrise < 64) begin
                    bits[63-nrise] = mdio_s;
                    oes[63-nrise]  = oe_s;
                end
                nrise++;
            end
            prev_mdc = mdc_s;
            if (busy_s !== 1'b1) busy_ok = 1'b0;
            if (c == 2*D*(pre+14))   oe_pre_ta = oe_s;
            if (c == 2*D*(pre+14)+1) oe_ta = oe_s;
            if (rsp_s === 1'b1) begin
                lat = c; rdata = rdata_s; err = err_s;
            end else begin
                idx = (c-1)/(2*D);
                j = idx - pre - 16;
                if (!phy_drive) mdio_in = 1'b1;
                else if (idx == pre+15) mdio_in = 1'b0;
                else if (j >= 0 && j < 16) mdio_in = phy_data[15-j];
                else mdio_in = 1'b1;
                if (c == junk_at) begin
                    if (s) valid_b = 1'b1; else valid_a = 1'b1;
                    req_phy = ~phy; req_wdata = ~wd; req_reg = ~regad;
                end
                if (c == junk_at+3) begin
                    valid_a = 1'b0; valid_b = 1'b0;
                end
                if (c == pause_at) begin
                    snap_mdc = mdc_s; snap_mdio = mdio_s; snap_oe = oe_s; snap_rsp = rsp_s;
                    cke = 1'b0;
                    repeat (50) begin
                        tick();
                        if (mdc_s !== snap_mdc || mdio_s !== snap_mdio ||
                            oe_s !== snap_oe || rsp_s !== snap_rsp) frozen_ok = 1'b0;
                    end
                    cke = 1'b1;
                    c += 50;
                end
                tick();
                c++;
            end
        end
        mdio_in = 1'b1;
        tick();
        ready_after = (ready_s === 1'b1) && (rsp_s === 1'b0);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({ready_a, rsp_a, err_a, busy_a, mdc_a, mdio_a, oe_a} !== 7'b1000010) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl_a: got %b expected %b",
                     {ready_a, rsp_a, err_a, busy_a, mdc_a, mdio_a, oe_a}, 7'b1000010);
        end
        n_cmp++;
        if (rdata_a !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata_a: got %h expected 0000", rdata_a);
        end
        n_cmp++;
        if ({ready_b, rsp_b, mdc_b, mdio_b, oe_b} !== 5'b10010) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl_b: got %b expected 10010",
                     {ready_b, rsp_b, mdc_b, mdio_b, oe_b});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_c22_write();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b0, 1'b1, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, 32, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 261) begin
            n_fail++; $display("[TB] FAIL c22_write_latency: got %0d expected 261", lat);
        end
        n_cmp++;
        if (bits !== 64'hFFFFFFFF_50821140) begin
            n_fail++; $display("[TB] FAIL c22_write_bits: got %h expected FFFFFFFF50821140", bits);
        end
        n_cmp++;
        if (oes !== {64{1'b1}}) begin
            n_fail++; $display("[TB] FAIL c22_write_oe: got %h expected all ones", oes);
        end
        n_cmp++;
        if ({er, rd, bz, rdy} !== {1'b0, 16'h0000, 1'b1, 1'b1}) begin
            n_fail++; $display("[TB] FAIL c22_write_rsp: got err=%b rdata=%h busy=%b ready=%b expected 0 0000 1 1",
                               er, rd, bz, rdy);
        end
    endtask

    task automatic test_c22_read();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b0, 1'b1, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h0022, 32, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 261 || rd !== 16'h0022 || er !== 1'b0) begin
            n_fail++; $display("[TB] FAIL c22_read_rsp: got lat=%0d rdata=%h err=%b expected 261 0022 0",
                               lat, rd, er);
        end
        n_cmp++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL c22_read_oe_edge: got before=%b at_ta=%b expected 1 0", a1, a2);
        end
        n_cmp++;
        if (oes !== 64'hFFFFFFFF_FFFC0000) begin
            n_fail++; $display("[TB] FAIL c22_read_oe: got %h expected FFFFFFFFFFFC0000", oes);
        end
        n_cmp++;
        if (bits[63:18] !== {32'hFFFFFFFF, 14'b01100001100010}) begin
            n_fail++; $display("[TB] FAIL c22_read_hdr: got %h expected %h",
                               bits[63:18], {32'hFFFFFFFF, 14'b01100001100010});
        end
        n_cmp++;
        if (rdata_s !== 16'h0022) begin
            n_fail++; $display("[TB] FAIL c22_read_hold: got %h expected 0022", rdata_s);
        end
        do_frame(1'b0, 1'b1, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 16'h0, 32, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 261 || rd !== 16'hFFFF || er !== 1'b1) begin
            n_fail++; $display("[TB] FAIL c22_read_silent: got lat=%0d rdata=%h err=%b expected 261 FFFF 1",
                               lat, rd, er);
        end
    endtask

    task automatic test_no_preamble();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b1, 1'b1, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, 0, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 133) begin
            n_fail++; $display("[TB] FAIL nopre_latency: got %0d expected 133", lat);
        end
        n_cmp++;
        if (bits[63:31] !== {32'h50821140, 1'b1}) begin
            n_fail++; $display("[TB] FAIL nopre_bits: got %h expected %h", bits[63:31], {32'h50821140, 1'b1});
        end
        n_cmp++;
        if (oes[63:31] !== {32'hFFFFFFFF, 1'b0}) begin
            n_fail++; $display("[TB] FAIL nopre_oe: got %h expected %h", oes[63:31], {32'hFFFFFFFF, 1'b0});
        end
    endtask

    task automatic test_illegal();
        sel = 1'b0;
        req_st = 1'b0; req_op = 2'b01; req_phy = 5'h01; req_reg = 5'h01; req_wdata = 16'h0;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_cmp++;
        if ({rsp_s, err_s, rdata_s, mdc_s, oe_s, ready_s} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL illegal_st0: got rsp=%b err=%b rdata=%h mdc=%b oe=%b ready=%b expected 1 1 0000 0 0 0",
                               rsp_s, err_s, rdata_s, mdc_s, oe_s, ready_s);
        end
        tick();
        n_cmp++;
        if (ready_s !== 1'b1 || rsp_s !== 1'b0 || mdc_s !== 1'b0) begin
            n_fail++; $display("[TB] FAIL illegal_return: got ready=%b rsp=%b mdc=%b expected 1 0 0",
                               ready_s, rsp_s, mdc_s);
        end
        req_st = 1'b1; req_op = 2'b11;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_cmp++;
        if (rsp_s !== 1'b1 || err_s !== 1'b1 || oe_s !== 1'b0) begin
            n_fail++; $display("[TB] FAIL illegal_op11: got rsp=%b err=%b oe=%b expected 1 1 0", rsp_s, err_s, oe_s);
        end
        tick();
    endtask

    task automatic test_c45_addr();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b1, 1'b0, 2'b00, 5'h01, 5'h01, 16'h0010, 1'b0, 16'h0, 0, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (bits[63:32] !== 32'h00860010) begin
            n_fail++; $display("[TB] FAIL c45_addr_bits: got %h expected 00860010", bits[63:32]);
        end
        n_cmp++;
        if (lat !== 133 || er !== 1'b0) begin
            n_fail++; $display("[TB] FAIL c45_addr_rsp: got lat=%0d err=%b expected 133 0", lat, er);
        end
    endtask

    task automatic test_cke_freeze();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b0, 1'b1, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, 32, 220, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 311) begin
            n_fail++; $display("[TB] FAIL cke_latency: got %0d expected 311", lat);
        end
        n_cmp++;
        if (fz !== 1'b1) begin
            n_fail++; $display("[TB] FAIL cke_frozen: got %b expected 1", fz);
        end
        n_cmp++;
        if (bits !== 64'hFFFFFFFF_50821140) begin
            n_fail++; $display("[TB] FAIL cke_bits: got %h expected FFFFFFFF50821140", bits);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] bits, oes; logic a1, a2, fz, bz, er, rdy; logic [15:0] rd;
        do_frame(1'b0, 1'b1, 2'b01, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0, 32, 0, 60,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 261 || bits !== 64'hFFFFFFFF_5FFEA5C3) begin
            n_fail++; $display("[TB] FAIL b2b_first: got lat=%0d bits=%h expected 261 FFFFFFFF5FFEA5C3", lat, bits);
        end
        do_frame(1'b0, 1'b1, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h1234, 32, 0, 0,
                 lat, bits, oes, a1, a2, fz, bz, rd, er, rdy);
        n_cmp++;
        if (lat !== 261 || rd !== 16'h1234 || er !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_second: got lat=%0d rdata=%h err=%b expected 261 1234 0", lat, rd, er);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic saw_rsp;
        sel = 1'b0;
        req_st = 1'b1; req_op = 2'b01; req_phy = 5'h01; req_reg = 5'h00; req_wdata = 16'h1140;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        repeat (139) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({mdc_s, oe_s, mdio_s, ready_s, rsp_s, busy_s} !== 6'b001100) begin
            n_fail++; $display("[TB] FAIL reset_mid_hdr: got mdc/oe/mdio/ready/rsp/busy=%b expected 001100",
                               {mdc_s, oe_s, mdio_s, ready_s, rsp_s, busy_s});
        end
        saw_rsp = 1'b0;
        repeat (400) begin
            tick();
            if (rsp_s !== 1'b0 || mdc_s !== 1'b0) saw_rsp = 1'b1;
        end
        n_cmp++;
        if (saw_rsp !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_no_rsp: got activity=%b expected 0", saw_rsp);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        cke = 1'b1; rst = 1'b1; mdio_in = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sel = 1'b0;
        req_st = 1'b1; req_op = 2'b01; req_phy = '0; req_reg = '0; req_wdata = '0;
        test_reset();
        test_c22_write();
        test_c22_read();
        test_no_preamble();
        test_illegal();
        test_c45_addr();
        test_cke_freeze();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
